// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter and its future read-side siblings.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int COUNT_W = 32;

  function automatic int tagged_width(input int id_len, input int data_len);
    return id_len + data_len;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Producer handshake plus FIFO write port; master is the arbiter, slave is producers/FIFO.
interface fifo_arb_if #(
  parameter int DATA_LEN = 16,
  parameter int NUM_REQ  = 4,
  parameter int ID_LEN   = $clog2(NUM_REQ)
);
  import fifo_arb_pkg::*;

  logic [NUM_REQ-1:0]                       req_valid;
  logic [NUM_REQ*DATA_LEN-1:0]              req_data;
  logic [NUM_REQ-1:0]                       req_ready;
  logic                                     wrt_en;
  logic [tagged_width(ID_LEN, DATA_LEN)-1:0] data_in;
  logic                                     wrt_full;

  modport master (
    input  req_valid, req_data, wrt_full,
    output req_ready, wrt_en, data_in
  );

  modport slave (
    output req_valid, req_data, wrt_full,
    input  req_ready, wrt_en, data_in
  );

endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request bit at or after start, wrapping at N.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan farthest offset first so the nearest set bit is the last (winning) write.
  always_comb begin
    int pos;
    pos   = 0;
    idx   = '0;
    found = 1'b0;
    for (int off = N - 1; off >= 0; off--) begin
      pos = int'(start) + off;
      if (pos >= N) pos = pos - N;
      if (req[pos[IDX_W-1:0]]) begin
        idx   = pos[IDX_W-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ tagged producers.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_LEN  = 16,
  parameter int NUM_REQ   = 4,
  parameter int ID_LEN    = $clog2(NUM_REQ),
  parameter int BURST_LEN = 8
) (
  input  logic               clk,
  input  logic               reset,
  fifo_arb_if.master         bus,
  output logic [ID_LEN-1:0]  grant_id,
  output logic               busy,
  output logic [COUNT_W-1:0] word_count
);

  localparam logic [0:0] S_IDLE    = IDLE;
  localparam logic [0:0] S_BURST   = BURST;
  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

  logic [0:0]        state;
  logic [ID_LEN-1:0] rr_ptr;
  logic [ID_LEN-1:0] pick_idx;
  logic [ID_LEN-1:0] next_ptr;
  logic              pick_found;
  logic [7:0]        beat_cnt;
  logic              grant_valid;
  logic              accept;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (ID_LEN)
  ) u_pick (
    .req   (bus.req_valid),
    .start (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign busy        = (state == S_BURST);
  assign grant_valid = bus.req_valid[grant_id];
  assign accept      = busy & grant_valid & ~bus.wrt_full;
  assign bus.wrt_en  = accept;
  assign bus.data_in = {grant_id, bus.req_data[int'(grant_id)*DATA_LEN +: DATA_LEN]};
  assign next_ptr    = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + ID_LEN'(1);

  // Ready follows only FIFO space, so a full FIFO stalls without ending the burst.
  always_comb begin
    bus.req_ready = '0;
    if (busy && !bus.wrt_full) bus.req_ready[grant_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      grant_id   <= '0;
      beat_cnt   <= '0;
      word_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            grant_id <= pick_idx;
            beat_cnt <= '0;
            state    <= S_BURST;
          end
        end
        S_BURST: begin
          if (accept) begin
            beat_cnt   <= beat_cnt + 8'd1;
            word_count <= word_count + COUNT_W'(1);
            if (beat_cnt == LAST_BEAT) begin
              state  <= S_IDLE;
              rr_ptr <= next_ptr;
            end
          end else if (!grant_valid) begin
            state  <= S_IDLE;
            rr_ptr <= next_ptr;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: a BURST_LEN=8 instance with a producer model
// and a BURST_LEN=2 instance with all requesters permanently valid.
module tb_fifo_write_arbiter;
  import fifo_arb_pkg::*;

  localparam int DATA_LEN = 16;
  localparam int NUM_REQ  = 4;
  localparam int ID_LEN   = 2;

  logic clk;
  logic reset;

  fifo_arb_if #(.DATA_LEN(DATA_LEN), .NUM_REQ(NUM_REQ), .ID_LEN(ID_LEN)) bus ();
  fifo_arb_if #(.DATA_LEN(DATA_LEN), .NUM_REQ(NUM_REQ), .ID_LEN(ID_LEN)) bus2 ();

  logic [ID_LEN-1:0] grant_id, grant_id2;
  logic              busy, busy2;
  logic [31:0]       word_count, word_count2;

  fifo_write_arbiter #(
    .DATA_LEN(DATA_LEN), .NUM_REQ(NUM_REQ), .ID_LEN(ID_LEN), .BURST_LEN(8)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .grant_id(grant_id), .busy(busy), .word_count(word_count)
  );

  fifo_write_arbiter #(
    .DATA_LEN(DATA_LEN), .NUM_REQ(NUM_REQ), .ID_LEN(ID_LEN), .BURST_LEN(2)
  ) dut2 (
    .clk(clk), .reset(reset), .bus(bus2),
    .grant_id(grant_id2), .busy(busy2), .word_count(word_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          remaining [NUM_REQ];
  logic [15:0] next_word [NUM_REQ];
  logic        drive_full;

  logic               s_wrt_en, s_busy;
  logic [NUM_REQ-1:0] s_ready;
  logic [ID_LEN-1:0]  s_grant;
  logic [17:0]        s_data;
  logic [31:0]        s_count;

  int          wr_ids[$];
  int          wr_cycles[$];
  logic [15:0] wr_data[$];

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_valid[i] = (remaining[i] > 0);
      bus.req_data[i*DATA_LEN +: DATA_LEN] = next_word[i];
    end
    bus.wrt_full = drive_full;
  endtask

  task automatic apply_stimulus(input int r0, input int r1, input int r2, input int r3);
    remaining[0] = r0;
    remaining[1] = r1;
    remaining[2] = r2;
    remaining[3] = r3;
    wr_ids.delete();
    wr_cycles.delete();
    wr_data.delete();
    drive_inputs();
  endtask

  // One cycle: sample at negedge, then let producers consume accepted words after posedge.
  task automatic tick(input int cyc);
    @(negedge clk);
    s_wrt_en = bus.wrt_en;
    s_busy   = busy;
    s_ready  = bus.req_ready;
    s_grant  = grant_id;
    s_data   = bus.data_in;
    s_count  = word_count;
    if (s_wrt_en) begin
      wr_ids.push_back(int'(s_data[17:16]));
      wr_cycles.push_back(cyc);
      wr_data.push_back(s_data[15:0]);
    end
    @(posedge clk);
    #1;
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_valid[i] && s_ready[i]) begin
          remaining[i]--;
          next_word[i]++;
        end
      end
    end
    drive_inputs();
  endtask

  initial begin
    int          pattern_bad;
    int          stall_bad;
    int          id_bad;
    logic [19:0] ids_packed;
    logic        busy14, busy4, wen4;
    logic        r_busy, r_wen;
    logic [NUM_REQ-1:0] r_ready;
    logic [ID_LEN-1:0]  r_grant;
    logic [31:0] r_count, cnt3;
    logic [17:0] r_data;

    reset      = 1'b1;
    drive_full = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      remaining[i] = 0;
      next_word[i] = 16'h0000;
    end
    next_word[0] = 16'hA5A5;
    drive_inputs();
    bus2.req_valid = 4'hF;
    bus2.req_data  = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
    bus2.wrt_full  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_busy", busy, 1'b0);
    check_output("rst_wrt_en", bus.wrt_en, 1'b0);
    check_output("rst_ready", bus.req_ready, 4'h0);
    check_output("rst_grant", grant_id, 2'd0);
    check_output("rst_count", word_count, 32'd0);
    check_output("rst_data_in", bus.data_in, {2'd0, 16'hA5A5});

    // All four valid, BURST_LEN=2: grants 0,1,2,3,0 and every third cycle idle
    @(posedge clk);
    #1;
    reset       = 1'b0;
    pattern_bad = 0;
    ids_packed  = '0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if ((k % 3 == 0) == bus2.wrt_en) pattern_bad++;
      if (bus2.wrt_en) ids_packed = {ids_packed[17:0], bus2.data_in[17:16]};
    end
    @(negedge clk);
    check_output("rr2_idle_pattern", pattern_bad, 0);
    check_output("rr2_grant_order", ids_packed, 20'h05AF0);
    check_output("rr2_word_count", word_count2, 32'd10);

    // Single requester 2 with 20 words: bursts 8, 8, 4
    @(posedge clk);
    #1;
    next_word[2] = 16'h2000;
    apply_stimulus(0, 0, 20, 0);
    for (int c = 0; c < 28; c++) tick(c);
    id_bad = 0;
    foreach (wr_ids[i]) if (wr_ids[i] != 2) id_bad++;
    check_output("single_writes", wr_cycles.size(), 20);
    check_output("single_first_cycle", wr_cycles[0], 1);
    check_output("single_burst1_end", wr_cycles[7], 8);
    check_output("single_burst2_start", wr_cycles[8], 10);
    check_output("single_burst2_end", wr_cycles[15], 17);
    check_output("single_burst3_start", wr_cycles[16], 19);
    check_output("single_burst3_end", wr_cycles[19], 22);
    check_output("single_tag", id_bad, 0);
    check_output("single_last_data", wr_data[19], 16'h2013);
    check_output("single_word_count", word_count, 32'd20);

    // Backpressure: full for cycles 4..8 after three beats of requester 0
    next_word[0] = 16'h0100;
    apply_stimulus(8, 0, 0, 0);
    stall_bad = 0;
    busy14    = 1'b1;
    for (int c = 0; c < 20; c++) begin
      drive_full   = (c >= 4 && c <= 8);
      bus.wrt_full = drive_full;
      tick(c);
      if (c >= 4 && c <= 8 && (s_wrt_en || s_ready != '0 || !s_busy || s_grant != 2'd0))
        stall_bad++;
      if (c == 14) busy14 = s_busy;
    end
    drive_full   = 1'b0;
    bus.wrt_full = 1'b0;
    check_output("bp_stall_quiet", stall_bad, 0);
    check_output("bp_writes", wr_cycles.size(), 8);
    check_output("bp_beat3_cycle", wr_cycles[2], 3);
    check_output("bp_resume_cycle", wr_cycles[3], 9);
    check_output("bp_last_cycle", wr_cycles[7], 13);
    check_output("bp_last_data", wr_data[7], 16'h0107);
    check_output("bp_idle_after", busy14, 1'b0);

    // Requester 1 drops after 3 words; next goes to 2, then wraps to 0
    next_word[0] = 16'h0A00;
    next_word[1] = 16'h1A00;
    next_word[2] = 16'h2A00;
    apply_stimulus(2, 3, 2, 0);
    busy4 = 1'b0;
    wen4  = 1'b1;
    for (int c = 0; c < 16; c++) begin
      tick(c);
      if (c == 4) begin
        busy4 = s_busy;
        wen4  = s_wrt_en;
      end
    end
    ids_packed = '0;
    foreach (wr_ids[i]) ids_packed = {ids_packed[17:0], wr_ids[i][1:0]};
    check_output("drop_order", ids_packed, 20'h015A0);
    check_output("drop_cycle_busy", busy4, 1'b1);
    check_output("drop_cycle_no_write", wen4, 1'b0);
    check_output("drop_next_cycle", wr_cycles[3], 6);
    check_output("drop_req2_data", wr_data[3], 16'h2A00);

    // Drop with requester 2 idle: wraps to requester 0
    next_word[0] = 16'h0C00;
    next_word[1] = 16'h1C00;
    apply_stimulus(2, 3, 0, 0);
    for (int c = 0; c < 12; c++) tick(c);
    ids_packed = '0;
    foreach (wr_ids[i]) ids_packed = {ids_packed[17:0], wr_ids[i][1:0]};
    check_output("wrap_order", ids_packed, 20'h00150);
    check_output("wrap_next_cycle", wr_cycles[3], 6);

    // Reset during beat 4 of requester 3; search restarts at requester 0
    next_word[3] = 16'h3000;
    next_word[0] = 16'h0B00;
    apply_stimulus(0, 0, 0, 8);
    wen4 = 1'b0;
    for (int c = 0; c < 21; c++) begin
      if (c == 4) begin
        reset        = 1'b1;
        remaining[0] = 1;
        drive_inputs();
      end
      if (c == 6) reset = 1'b0;
      tick(c);
      if (c == 4) wen4 = s_wrt_en;
      if (c == 5) begin
        r_busy  = s_busy;
        r_wen   = s_wrt_en;
        r_ready = s_ready;
        r_grant = s_grant;
        r_count = s_count;
        r_data  = s_data;
      end
    end
    check_output("mid_beat4_inflight", wen4, 1'b1);
    check_output("mid_rst_busy", r_busy, 1'b0);
    check_output("mid_rst_wrt_en", r_wen, 1'b0);
    check_output("mid_rst_ready", r_ready, 4'h0);
    check_output("mid_rst_grant", r_grant, 2'd0);
    check_output("mid_rst_count", r_count, 32'd0);
    check_output("mid_rst_data_in", r_data, {2'd0, 16'h0B00});
    check_output("mid_first_id", wr_ids[4], 0);
    check_output("mid_first_cycle", wr_cycles[4], 7);
    check_output("mid_resend_data", wr_data[5], 16'h3003);
    check_output("mid_word_count", word_count, 32'd6);

    // Counter wrap from FFFF_FFFE through three writes
    force dut.word_count = 32'hFFFF_FFFE;
    #1;
    release dut.word_count;
    next_word[2] = 16'h2E00;
    apply_stimulus(0, 0, 3, 0);
    cnt3 = '1;
    for (int c = 0; c < 8; c++) begin
      tick(c);
      if (c == 3) cnt3 = s_count;
    end
    check_output("wrap_count_zero", cnt3, 32'd0);
    check_output("wrap_count_final", word_count, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
